// File: rtl/serial_add.sv
// serial_add: bit-serial WIDTH-bit adder, one full-adder cell plus a carry flop,
// operands in and result out over valid/ready handshakes.

module add (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q, sum_q;
    logic [WIDTH-1:0] sum_sr_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, c_out_q, in_ready_q, out_valid_q, busy_q;
    logic             cell_sum, cell_c_out;

    add u_add (
        .a     (a_sr_q[0]),
        .b     (b_sr_q[0]),
        .c_in  (carry_q),
        .sum   (cell_sum),
        .c_out (cell_c_out)
    );

    // New sum bit enters at the MSB; written as a shift so WIDTH=1 needs no special case.
    assign sum_sr_d = WIDTH'({cell_sum, sum_sr_q} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_sr_q    <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            c_out_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_sr_q     <= a;
                        b_sr_q     <= b;
                        carry_q    <= c_in;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_sr_q <= sum_sr_d;
                    carry_q  <= cell_c_out;
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        sum_q       <= sum_sr_d;
                        c_out_q     <= cell_c_out;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_serial_add.sv
// tb_serial_add: randomized and directed checks of serial_add (WIDTH=8 and WIDTH=1)
// against a plain-arithmetic reference.

module tb_serial_add;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0, c_in = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       in_ready, out_valid, c_out, busy;
    logic [7:0] sum;

    logic       in_valid1 = 1'b0, out_ready1 = 1'b0, c_in1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       in_ready1, out_valid1, c_out1, busy1;
    logic [0:0] sum1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_add #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .busy(busy)
    );

    serial_add #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .c_in(c_in1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .c_out(c_out1), .busy(busy1)
    );

    function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + 9'(c);
    endfunction

    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        int n = 0;
        a = ta; b = tb; c_in = tc; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic take;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, busy, sum, c_out} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset: rdy/vld/busy/sum/co=%b/%b/%b/%h/%b required 1/0/0/00/0",
                     in_ready, out_valid, busy, sum, c_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [7:0] va [3] = '{8'h3C, 8'hFF, 8'hA5};
        logic [7:0] vb [3] = '{8'h42, 8'h01, 8'h5A};
        logic       vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [8:0] exp_r [3] = '{9'h07E, 9'h100, 9'h100};
        int lat;
        for (int i = 0; i < 3; i++) begin
            start_op(va[i], vb[i], vc[i]);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_run[%0d]: busy=%b required 1", i, busy);
            end
            wait_valid(lat);
            checks++;
            if (lat != 8) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d required 8", i, lat);
            end
            checks++;
            if ({c_out, sum} !== exp_r[i]) begin
                errors++;
                $display("FAIL directed[%0d]: {c_out,sum}=%h required %h", i, {c_out, sum}, exp_r[i]);
            end
            take();
        end
    endtask

    task automatic test_random;
        logic [7:0] x, y;
        logic       c;
        logic [8:0] e;
        int lat;
        for (int i = 0; i < 25; i++) begin
            x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
            e = ref_add(x, y, c);
            start_op(x, y, c);
            wait_valid(lat);
            checks++;
            if ({c_out, sum} !== e || lat != 8) begin
                errors++;
                $display("FAIL random[%0d]: %h+%h+%b gave %h lat %0d required %h lat 8",
                         i, x, y, c, {c_out, sum}, lat, e);
            end
            take();
        end
    endtask

    task automatic test_backpressure;
        logic [8:0] e = ref_add(8'h81, 8'h93, 1'b1);
        int lat;
        start_op(8'h81, 8'h93, 1'b1);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, in_ready, c_out, sum} !== {1'b1, 1'b0, e}) begin
                errors++;
                $display("FAIL backpressure[%0d]: vld/rdy/res=%b/%b/%h required 1/0/%h",
                         i, out_valid, in_ready, {c_out, sum}, e);
            end
            @(posedge clk); #1;
        end
        take();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({out_valid, in_ready, busy} !== 3'b010) begin
                errors++;
                $display("FAIL bp_release[%0d]: vld/rdy/busy=%b/%b/%b required 0/1/0",
                         i, out_valid, in_ready, busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_in_run;
        logic [8:0] e1 = ref_add(8'h11, 8'h22, 1'b0);
        logic [8:0] e2 = ref_add(8'hF0, 8'h0F, 1'b1);
        int lat;
        start_op(8'h11, 8'h22, 1'b0);
        a = 8'hF0; b = 8'h0F; c_in = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_run: in_ready=%b required 0", in_ready);
        end
        wait_valid(lat);
        checks++;
        if ({c_out, sum} !== e1 || lat != 7) begin
            errors++;
            $display("FAIL ignore_run: res=%h lat %0d required %h lat 7", {c_out, sum}, lat, e1);
        end
        take();
        start_op(8'hF0, 8'h0F, 1'b1);
        wait_valid(lat);
        checks++;
        if ({c_out, sum} !== e2) begin
            errors++;
            $display("FAIL second_op: res=%h required %h", {c_out, sum}, e2);
        end
        take();
    endtask

    task automatic test_reset_mid_run;
        int lat;
        start_op(8'h77, 8'h66, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, busy, sum, c_out} !== {1'b0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: vld/rdy/busy/sum/co=%b/%b/%b/%h/%b required 0/1/0/00/0",
                     out_valid, in_ready, busy, sum, c_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_op(8'h01, 8'h01, 1'b0);
        wait_valid(lat);
        checks++;
        if ({c_out, sum} !== 9'h002 || lat != 8) begin
            errors++;
            $display("FAIL after_reset: res=%h lat %0d required 002 lat 8", {c_out, sum}, lat);
        end
        take();
    endtask

    task automatic test_width1;
        int lat;
        logic [1:0] e;
        for (int i = 0; i < 8; i++) begin
            c_in1 = i[2]; a1 = i[1]; b1 = i[0]; in_valid1 = 1'b1;
            lat = 0;
            while (!in_ready1 && lat < 50) begin
                @(posedge clk); #1; lat++;
            end
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            lat = 0;
            while (!out_valid1 && lat < 50) begin
                @(posedge clk); #1; lat++;
            end
            e = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
            checks++;
            if ({c_out1, sum1} !== e || lat != 1) begin
                errors++;
                $display("FAIL width1[%0d]: res=%b lat %0d required %b lat 1", i, {c_out1, sum1}, lat, e);
            end
            out_ready1 = 1'b1;
            @(posedge clk); #1;
            out_ready1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_ignore_in_run();
        test_reset_mid_run();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
